spi_cs_arbiter: RTL and testbench

SPI_CS_ARBITER -- requirements
Module: spi_cs_arbiter

---
 rtl/spi_cs_arbiter.sv | 97 +++++++++
 tb/tb_spi_cs_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/spi_cs_arbiter.sv
// spi_cs_arbiter: round-robin owner of a shared SPI bus between SD card and LCD with CS setup/hold/guard timing and grant timeout
module spi_cs_arbiter #(
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 4,
    parameter int GUARD    = 2,
    parameter int TIMEOUT  = 65535
) (
    input  logic clk27,
    input  logic reset_n,
    input  logic req_sd,
    input  logic req_lcd,
    input  logic tmo_clr,
    output logic gnt_sd,
    output logic gnt_lcd,
    output logic sd_ss_n,
    output logic lcd_cs_n,
    output logic busy,
    output logic tmo_flag,
    output logic tmo_src
);
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ACTIVE, S_HOLD, S_GUARD} state_t;
    state_t state, state_n;
    logic owner, owner_n, last_owner, last_n;
    logic rearm_sd, rearm_sd_n, rearm_lcd, rearm_lcd_n;
    logic elig_sd, elig_lcd, own_req, tmo_hit, sel_n;
    logic [15:0] cnt, cnt_n;
    // next state, owner choice, phase counter and timeout detection
    always_comb begin
        elig_sd = req_sd & rearm_sd;
        elig_lcd = req_lcd & rearm_lcd;
        own_req = owner ? req_lcd : req_sd;
        state_n = state;
        owner_n = owner;
        last_n = last_owner;
        tmo_hit = 1'b0;
        case (state)
            S_IDLE:
                if (elig_sd | elig_lcd) begin
                    state_n = S_SETUP;
                    owner_n = (elig_sd & elig_lcd) ? ~last_owner : elig_lcd;
                end
            S_SETUP:
                if (!own_req) state_n = S_HOLD;
                else if (cnt == 16'(CS_SETUP - 1)) state_n = S_ACTIVE;
            S_ACTIVE:
                if (!own_req) state_n = S_HOLD;
                else if (cnt == 16'(TIMEOUT - 1)) begin
                    state_n = S_HOLD;
                    tmo_hit = 1'b1;
                end
            S_HOLD:
                if (cnt == 16'(CS_HOLD - 1)) begin
                    state_n = S_GUARD;
                    last_n = owner;
                end
            S_GUARD:
                if (cnt == 16'(GUARD - 1)) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        cnt_n = (state_n != state || state == S_IDLE) ? 16'd0 : cnt + 16'd1;
        rearm_sd_n = (tmo_hit && !owner) ? 1'b0 : (rearm_sd | ~req_sd);
        rearm_lcd_n = (tmo_hit && owner) ? 1'b0 : (rearm_lcd | ~req_lcd);
        sel_n = state_n inside {S_SETUP, S_ACTIVE, S_HOLD};
    end
    // state and registered outputs, all taken from next-state values
    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            owner <= 1'b0;
            last_owner <= 1'b1;
            cnt <= 16'd0;
            rearm_sd <= 1'b1;
            rearm_lcd <= 1'b1;
            gnt_sd <= 1'b0;
            gnt_lcd <= 1'b0;
            sd_ss_n <= 1'b1;
            lcd_cs_n <= 1'b1;
            busy <= 1'b0;
            tmo_flag <= 1'b0;
            tmo_src <= 1'b0;
        end else begin
            state <= state_n;
            owner <= owner_n;
            last_owner <= last_n;
            cnt <= cnt_n;
            rearm_sd <= rearm_sd_n;
            rearm_lcd <= rearm_lcd_n;
            gnt_sd <= state_n == S_ACTIVE && !owner_n;
            gnt_lcd <= state_n == S_ACTIVE && owner_n;
            sd_ss_n <= !(sel_n && !owner_n);
            lcd_cs_n <= !(sel_n && owner_n);
            busy <= state_n != S_IDLE;
            tmo_flag <= tmo_hit | (tmo_flag & ~tmo_clr);
            tmo_src <= tmo_hit ? owner : tmo_src;
        end
    end
endmodule

// File: tb/tb_spi_cs_arbiter.sv
// tb_spi_cs_arbiter: directed vector table plus hand-written corner sequences for spi_cs_arbiter
module tb_spi_cs_arbiter;
    logic clk27 = 1'b0, reset_n = 1'b0, req_sd = 1'b0, req_lcd = 1'b0, tmo_clr = 1'b0;
    logic gnt_sd, gnt_lcd, sd_ss_n, lcd_cs_n, busy, tmo_flag, tmo_src;
    int total = 0, bad = 0;
    typedef struct {
        logic rs;
        logic rl;
        logic [4:0] exp;
    } vec_t;
    vec_t v[17];

    spi_cs_arbiter #(.TIMEOUT(8)) dut (
        .clk27(clk27), .reset_n(reset_n), .req_sd(req_sd), .req_lcd(req_lcd),
        .tmo_clr(tmo_clr), .gnt_sd(gnt_sd), .gnt_lcd(gnt_lcd), .sd_ss_n(sd_ss_n),
        .lcd_cs_n(lcd_cs_n), .busy(busy), .tmo_flag(tmo_flag), .tmo_src(tmo_src)
    );

    always #5 clk27 = ~clk27;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk27);
        #1;
    endtask

    // mutual exclusion of grants and selects on every cycle out of reset
    always @(negedge clk27) begin
        if (reset_n) begin
            total++;
            if ((gnt_sd && gnt_lcd) || (!sd_ss_n && !lcd_cs_n)) begin
                bad++;
                $display("FAIL overlap gnt=%b%b cs_n=%b%b required no overlap", gnt_sd, gnt_lcd, sd_ss_n, lcd_cs_n);
            end
        end
    end

    initial begin
        int t_gs_r, t_gs_f, t_idle, t_lcs, t_gl_r, hs, hl, n, t_r, t_f, nlow, ng;
        for (int k = 0; k < 17; k++) begin
            v[k].rs = k < 10;
            v[k].rl = 1'b0;
            v[k].exp = k < 4 ? 5'b00011 : k < 10 ? 5'b10011 : k < 14 ? 5'b00011 : k < 16 ? 5'b00111 : 5'b00110;
        end
        tick;
        tick;
        chk("rst_outs", {gnt_sd, gnt_lcd, sd_ss_n, lcd_cs_n, busy}, 5'b00110);
        chk("rst_tmo", {tmo_flag, tmo_src}, 0);
        reset_n = 1'b1;
        for (int k = 0; k < 17; k++) begin
            req_sd = v[k].rs;
            req_lcd = v[k].rl;
            tick;
            chk($sformatf("vec%0d {gs,gl,ss,cs,busy}", k), {gnt_sd, gnt_lcd, sd_ss_n, lcd_cs_n, busy}, v[k].exp);
        end
        chk("single_tmo_flag", tmo_flag, 0);

        reset_n = 1'b0;
        tick;
        reset_n = 1'b1;
        req_sd = 1'b1;
        req_lcd = 1'b1;
        t_gs_r = -1; t_gs_f = -1; t_idle = -1; t_lcs = -1; t_gl_r = -1; hs = 0; hl = 0;
        for (int t = 1; t <= 60; t++) begin
            tick;
            if (gnt_sd) begin
                hs++;
                if (t_gs_r < 0) t_gs_r = t;
                if (hs == 5) req_sd = 1'b0;
            end else if (t_gs_r >= 0 && t_gs_f < 0) t_gs_f = t;
            if (t_gs_f >= 0 && !busy && t_idle < 0) t_idle = t;
            if (!lcd_cs_n && t_lcs < 0) t_lcs = t;
            if (gnt_lcd) begin
                hl++;
                if (t_gl_r < 0) t_gl_r = t;
                if (hl == 5) req_lcd = 1'b0;
            end
        end
        chk("tie_sd_grant", t_gs_r, 5);
        chk("tie_sd_gnt_fall_to_idle", t_idle - t_gs_f, 6);
        chk("tie_lcd_cs_low", t_lcs, 17);
        chk("tie_lcd_grant", t_gl_r, 21);
        chk("tie_lcd_cycles", hl, 5);

        req_lcd = 1'b1;
        n = 0; t_r = -1; t_f = -1;
        for (int t = 1; t <= 40; t++) begin
            tick;
            if (gnt_lcd) n++;
            if (gnt_lcd && t_r < 0) t_r = t;
            if (!gnt_lcd && t_r >= 0 && t_f < 0) t_f = t;
        end
        chk("tmo_grant", t_r, 5);
        chk("tmo_gnt_cycles", n, 8);
        chk("tmo_revoke", t_f, 13);
        chk("tmo_flag", tmo_flag, 1);
        chk("tmo_src", tmo_src, 1);
        chk("tmo_no_regrant_busy", busy, 0);
        req_lcd = 1'b0;
        tick;
        req_lcd = 1'b1;
        t_r = -1;
        for (int t = 1; t <= 10 && t_r < 0; t++) begin
            tick;
            if (gnt_lcd) t_r = t;
        end
        chk("tmo_regrant", t_r, 5);
        tmo_clr = 1'b1;
        tick;
        tmo_clr = 1'b0;
        chk("tmo_clr_flag", tmo_flag, 0);
        repeat (6) tick;
        chk("tmo2_gnt_before", gnt_lcd, 1);
        tmo_clr = 1'b1;
        tick;
        tmo_clr = 1'b0;
        chk("tmo_clr_coincide_flag", tmo_flag, 1);
        chk("tmo2_gnt_after", gnt_lcd, 0);
        req_lcd = 1'b0;
        repeat (10) tick;
        chk("tmo2_idle", busy, 0);

        req_sd = 1'b1;
        nlow = 0; ng = 0; t_idle = -1;
        for (int t = 1; t <= 20; t++) begin
            tick;
            if (t == 2) req_sd = 1'b0;
            if (!sd_ss_n) nlow++;
            if (gnt_sd) ng++;
            if (!busy && t > 1 && t_idle < 0) t_idle = t;
        end
        chk("abort_ss_low_cycles", nlow, 6);
        chk("abort_no_gnt", ng, 0);
        chk("abort_idle", t_idle, 9);

        req_lcd = 1'b1;
        t_r = -1;
        for (int t = 1; t <= 10 && t_r < 0; t++) begin
            tick;
            if (gnt_lcd) t_r = t;
        end
        chk("rstmid_grant", t_r, 5);
        tick;
        chk("rstmid_cs_before", lcd_cs_n, 0);
        reset_n = 1'b0;
        #2;
        chk("rstmid_async_outs", {gnt_sd, gnt_lcd, sd_ss_n, lcd_cs_n, busy}, 5'b00110);
        reset_n = 1'b1;
        t_lcs = -1; t_r = -1;
        for (int t = 1; t <= 10 && t_r < 0; t++) begin
            tick;
            if (!lcd_cs_n && t_lcs < 0) t_lcs = t;
            if (gnt_lcd) t_r = t;
        end
        chk("rstmid_cs_low", t_lcs, 1);
        chk("rstmid_regrant", t_r, 5);
        req_lcd = 1'b0;
        repeat (3) tick;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
